// File: rtl/joybus_poll_host_if.sv
// rtl/joybus_poll_host_if.sv - command/response bundle between a client and the JOYBUS poll host
interface joybus_poll_host_if #(
    parameter int MAX_TX_BYTES = 3,
    parameter int MAX_RX_BYTES = 4
);
    localparam int TXL_W = $clog2(MAX_TX_BYTES + 1);
    localparam int RXL_W = $clog2(MAX_RX_BYTES + 1);

    logic                      start;
    logic [TXL_W-1:0]          tx_len;
    logic [RXL_W-1:0]          rx_len;
    logic [8*MAX_TX_BYTES-1:0] tx_data;
    logic                      busy;
    logic                      done;
    logic                      timeout_err;
    logic [8*MAX_RX_BYTES-1:0] rx_data;
    logic [RXL_W-1:0]          rx_count;

    modport master (
        output start, tx_len, rx_len, tx_data,
        input  busy, done, timeout_err, rx_data, rx_count
    );

    modport slave (
        input  start, tx_len, rx_len, tx_data,
        output busy, done, timeout_err, rx_data, rx_count
    );
endinterface

// File: rtl/joybus_poll_host.sv
// rtl/joybus_poll_host.sv - JOYBUS host: sends a command, then decodes the device response
module joybus_poll_host #(
    parameter int US_CYCLES    = 50,
    parameter int MAX_TX_BYTES = 3,
    parameter int MAX_RX_BYTES = 4,
    parameter int TIMEOUT_US   = 100
) (
    input  logic               clk,
    input  logic               rst,
    joybus_poll_host_if.slave  bus,
    input  logic               jb_in,
    output logic               jb_drive_low
);
    localparam int TXL_W   = $clog2(MAX_TX_BYTES + 1);
    localparam int RXL_W   = $clog2(MAX_RX_BYTES + 1);
    localparam int TX_BITS = 8 * MAX_TX_BYTES;
    localparam int TXB_W   = $clog2(TX_BITS + 1);
    localparam int RXB_W   = $clog2(8 * MAX_RX_BYTES + 1);
    localparam int TO_CYC  = TIMEOUT_US * US_CYCLES;
    localparam int CNT_W   = $clog2(4 * US_CYCLES + 1);
    localparam int TMR_W   = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_SAMPLE, RX_STOP, FINISH
    } state_t;

    state_t                    state;
    logic                      sync1, sync2, line_d;
    logic [TX_BITS-1:0]        tx_seq;
    logic [TXB_W-1:0]          tx_left;
    logic [RXL_W-1:0]          rx_len_q;
    logic [RXB_W-1:0]          rx_bits;
    logic [6:0]                rx_shift;
    logic [CNT_W-1:0]          cnt;
    logic [TMR_W-1:0]          tmr;
    logic                      sampled, seen_fall;
    logic                      busy_q, done_q, tmo_q;
    logic [8*MAX_RX_BYTES-1:0] rx_data_q;
    logic [RXL_W-1:0]          rx_count_q;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = tmo_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_count    = rx_count_q;

    logic             cur_bit, level_same, fall, rise, rx_timeout, start_ok;
    logic [CNT_W-1:0] low_end, high_end;
    logic [RXB_W-1:0] rx_target;
    logic [7:0]       new_byte;
    logic [31:0]      tx_len_w, rx_len_w;

    // Transmit bits are pre-ordered on accept so the current bit is always the top one.
    assign cur_bit    = tx_seq[TX_BITS-1];
    assign low_end    = cur_bit ? CNT_W'(US_CYCLES - 1) : CNT_W'(3 * US_CYCLES - 1);
    assign high_end   = cur_bit ? CNT_W'(3 * US_CYCLES - 1) : CNT_W'(US_CYCLES - 1);
    assign level_same = (sync2 == line_d);
    assign fall       = line_d & ~sync2;
    assign rise       = ~line_d & sync2;
    assign rx_timeout = level_same && (tmr == TMR_W'(TO_CYC - 1)) &&
                        (!sync2 || state == RX_WAIT || state == RX_STOP);
    assign rx_target  = RXB_W'({rx_len_q, 3'b000});
    assign new_byte   = {rx_shift, sync2};
    assign tx_len_w   = 32'(bus.tx_len);
    assign rx_len_w   = 32'(bus.rx_len);
    assign start_ok   = bus.start && (tx_len_w != 0) &&
                        (tx_len_w <= 32'(MAX_TX_BYTES)) && (rx_len_w <= 32'(MAX_RX_BYTES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sync1        <= 1'b1;
            sync2        <= 1'b1;
            line_d       <= 1'b1;
            jb_drive_low <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tmo_q        <= 1'b0;
            rx_data_q    <= '0;
            rx_count_q   <= '0;
            tx_seq       <= '0;
            tx_left      <= '0;
            rx_len_q     <= '0;
            rx_bits      <= '0;
            rx_shift     <= '0;
            cnt          <= '0;
            tmr          <= '0;
            sampled      <= 1'b0;
            seen_fall    <= 1'b0;
        end else begin
            sync1  <= jb_in;
            sync2  <= sync1;
            line_d <= sync2;
            done_q <= 1'b0;
            // tmr holds (clocks spent at the current line level) - 1
            if (!level_same)
                tmr <= TMR_W'(1);
            else if (tmr != TMR_W'(TO_CYC))
                tmr <= tmr + 1'b1;

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state        <= TX_LOW;
                        busy_q       <= 1'b1;
                        jb_drive_low <= 1'b1;
                        cnt          <= '0;
                        tx_left      <= TXB_W'({bus.tx_len, 3'b000});
                        rx_len_q     <= bus.rx_len;
                        rx_bits      <= '0;
                        rx_data_q    <= '0;
                        rx_count_q   <= '0;
                        tmo_q        <= 1'b0;
                        for (int b = 0; b < MAX_TX_BYTES; b++)
                            for (int k = 0; k < 8; k++)
                                tx_seq[TX_BITS-1-8*b-k] <= bus.tx_data[8*b+7-k];
                    end
                end
                TX_LOW: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == low_end) begin
                        state        <= TX_HIGH;
                        jb_drive_low <= 1'b0;
                        cnt          <= '0;
                    end
                end
                TX_HIGH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == high_end) begin
                        cnt          <= '0;
                        jb_drive_low <= 1'b1;
                        tx_left      <= tx_left - 1'b1;
                        tx_seq       <= tx_seq << 1;
                        state        <= (tx_left == TXB_W'(1)) ? TX_STOP : TX_LOW;
                    end
                end
                TX_STOP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(US_CYCLES - 1))
                        jb_drive_low <= 1'b0;
                    if (cnt == CNT_W'(3 * US_CYCLES - 1)) begin
                        if (rx_len_q == '0) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            state <= RX_WAIT;
                            tmr   <= '0;
                        end
                    end
                end
                RX_WAIT: begin
                    if (rx_timeout) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        tmo_q  <= 1'b1;
                    end else if (fall) begin
                        state   <= RX_SAMPLE;
                        cnt     <= '0;
                        sampled <= 1'b0;
                    end
                end
                RX_SAMPLE: begin
                    if (rx_timeout) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        tmo_q  <= 1'b1;
                    end else if (!sampled) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(2 * US_CYCLES - 1)) begin
                            sampled  <= 1'b1;
                            rx_shift <= new_byte[6:0];
                            rx_bits  <= rx_bits + 1'b1;
                            if (rx_bits[2:0] == 3'd7) begin
                                rx_count_q <= rx_count_q + 1'b1;
                                for (int b = 0; b < MAX_RX_BYTES; b++)
                                    if (rx_count_q == RXL_W'(b))
                                        rx_data_q[8*b +: 8] <= new_byte;
                            end
                        end
                    end else if (sync2) begin
                        // Re-arm edge detection only once the line has returned high.
                        sampled <= 1'b0;
                        if (rx_bits == rx_target) begin
                            state     <= RX_STOP;
                            seen_fall <= 1'b0;
                        end else begin
                            state <= RX_WAIT;
                            tmr   <= '0;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_timeout) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        tmo_q  <= 1'b1;
                    end else if (fall) begin
                        seen_fall <= 1'b1;
                    end else if (rise && seen_fall) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_joybus_poll_host.sv
// tb/tb_joybus_poll_host.sv - randomized self-checking bench for joybus_poll_host
module tb_joybus_poll_host;
    localparam int US     = 4;
    localparam int TO_US  = 10;
    localparam int MTX    = 3;
    localparam int MRX    = 4;
    localparam int TO_CYC = US * TO_US;
    localparam int LIMIT  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic jb_in, jb_drive_low;
    logic dev_low = 1'b0;

    joybus_poll_host_if #(.MAX_TX_BYTES(MTX), .MAX_RX_BYTES(MRX)) bus();

    joybus_poll_host #(
        .US_CYCLES(US), .MAX_TX_BYTES(MTX), .MAX_RX_BYTES(MRX), .TIMEOUT_US(TO_US)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .jb_in(jb_in), .jb_drive_low(jb_drive_low)
    );

    // Open-drain line: either side pulling low wins.
    assign jb_in = ~(jb_drive_low | dev_low);
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;

    always @(negedge clk) if (bus.done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction: host waveform and device reply are derived from the bit-timing rules,
    // results from the set of complete bytes the device sends.
    task automatic run_txn(input int n_tx, input logic [23:0] txd, input int rxl,
                           input int dev_n, input logic [31:0] devd, input int tail,
                           input int delay, input bit poke_busy);
        logic        exp_w[$];
        logic        dev_w[$];
        logic [31:0] exp_data;
        int          t_len, exp_lat, done_at, wave_err, busy_err, d0;
        exp_data = '0;
        done_at  = -1;
        wave_err = 0;
        busy_err = 0;
        for (int b = 0; b < n_tx; b++)
            for (int k = 7; k >= 0; k--)
                for (int c = 0; c < 4*US; c++)
                    exp_w.push_back(c < (txd[8*b+k] ? US : 3*US));
        for (int c = 0; c < 3*US; c++) exp_w.push_back(c < US);
        t_len = exp_w.size();

        for (int c = 0; c < t_len + delay; c++) dev_w.push_back(1'b0);
        for (int b = 0; b < dev_n; b++)
            for (int k = 7; k >= 0; k--)
                for (int c = 0; c < 4*US; c++)
                    dev_w.push_back(c < (devd[8*b+k] ? US : 3*US));
        for (int t = 0; t < tail; t++)
            for (int c = 0; c < 4*US; c++) dev_w.push_back(c < US);
        if (rxl > 0 && dev_n == rxl)
            for (int c = 0; c < 3*US; c++) dev_w.push_back(c < 2*US);

        for (int b = 0; b < dev_n; b++) exp_data[8*b +: 8] = devd[8*b +: 8];
        exp_lat = (rxl == 0) ? t_len : ((dev_n == 0) ? t_len + TO_CYC : -1);

        d0 = done_seen;
        @(negedge clk);
        bus.tx_len  = 2'(n_tx);
        bus.rx_len  = 3'(rxl);
        bus.tx_data = txd;
        bus.start   = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            dev_low = (i < dev_w.size()) ? dev_w[i] : 1'b0;
            if (poke_busy && i == 20) begin
                bus.start   = 1'b1;
                bus.tx_data = 24'hFFFFFF;
                bus.tx_len  = 2'd1;
                bus.rx_len  = 3'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (jb_drive_low !== ((i < t_len) ? exp_w[i] : 1'b0)) wave_err++;
            if (bus.done === 1'b1) begin
                done_at = i;
                break;
            end
            if (bus.busy !== 1'b1) busy_err++;
            @(posedge clk);
            #1;
        end
        dev_low   = 1'b0;
        bus.start = 1'b0;
        check("done_reached", done_at >= 0, 1);
        check("tx_wave_errs", wave_err, 0);
        check("busy_during", busy_err, 0);
        check("busy_at_done", bus.busy, 0);
        if (exp_lat >= 0) check("done_latency", done_at, exp_lat);
        check("rx_count", bus.rx_count, dev_n);
        check("rx_data", bus.rx_data, exp_data);
        check("timeout_err", bus.timeout_err, (rxl > 0 && dev_n < rxl));
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("done_count", done_seen - d0, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int d0, n_tx, rxl, dev_n, tail;
        bus.start   = 1'b0;
        bus.tx_len  = '0;
        bus.rx_len  = '0;
        bus.tx_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_drive", jb_drive_low, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_tmo", bus.timeout_err, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_count", bus.rx_count, 0);

        run_txn(1, 24'h000001, 0, 0, 32'h0, 0, 5, 1'b0);
        run_txn(1, 24'h000001, 4, 4, 32'h34120080, 0, 6, 1'b1);
        run_txn(1, 24'h000001, 4, 0, 32'h0, 0, 6, 1'b0);
        run_txn(1, 24'h000001, 4, 2, 32'h000055AA, 0, 6, 1'b0);

        // Illegal requests in IDLE must be ignored.
        d0 = done_seen;
        @(negedge clk);
        bus.tx_len = 2'd0; bus.rx_len = 3'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.tx_len = 2'd1; bus.rx_len = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("ignored_busy", bus.busy, 0);
        check("ignored_drive", jb_drive_low, 0);
        check("ignored_done", done_seen - d0, 0);

        // Reset while the first bit is being driven low.
        @(negedge clk);
        bus.tx_len = 2'd1; bus.rx_len = 3'd0; bus.tx_data = 24'h0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_drive", jb_drive_low, 1);
        d0 = done_seen;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_drive", jb_drive_low, 0);
        check("post_rst_busy", bus.busy, 0);
        repeat (60) @(negedge clk);
        check("post_rst_no_done", done_seen - d0, 0);

        for (int it = 0; it < 12; it++) begin
            n_tx  = $urandom_range(1, MTX);
            rxl   = $urandom_range(0, MRX);
            dev_n = (rxl == 0) ? 0 : (($urandom_range(0, 2) == 0) ? $urandom_range(0, rxl - 1) : rxl);
            tail  = (dev_n > 0 && dev_n < rxl) ? $urandom_range(1, 7) : 0;
            run_txn(n_tx, 24'($urandom), rxl, dev_n, $urandom, tail,
                    $urandom_range(1, 20), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/joybus_poll_host.md
JOYBUS_POLL_HOST -- requirements
Module: joybus_poll_host

Interface
REQ-001 Parameter US_CYCLES, default 50, clk cycles per 1 us (legal ≥2).
REQ-002 Parameter MAX_TX_BYTES, default 3, maximum command bytes per transaction.
REQ-003 Parameter MAX_RX_BYTES, default 4, maximum response bytes per transaction.
REQ-004 Parameter TIMEOUT_US, default 100, maximum idle-high time while awaiting a response edge.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle transaction request.
REQ-008 tx_len  in  clog2(MAX_TX_BYTES+1)  command byte count.
REQ-009 rx_len  in  clog2(MAX_RX_BYTES+1)  expected response byte count.
REQ-010 tx_data  in  8*MAX_TX_BYTES  command bytes; byte 0 = bits [7:0], sent first, MSB first.
REQ-011 jb_in  in  1  raw JOYBUS line level, asynchronous.
REQ-012 jb_drive_low  out  1  1 = pull line low, 0 = release line to high-Z (external pad logic).
REQ-013 busy  out  1  transaction in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 timeout_err  out  1  last transaction ended on timeout; valid from done until next start.
REQ-016 rx_data  out  8*MAX_RX_BYTES  received bytes, byte 0 in bits [7:0], MSB-first per byte.
REQ-017 rx_count  out  clog2(MAX_RX_BYTES+1)  complete bytes received in last transaction.

Function
REQ-018 jb_in SHALL pass a 2-flop synchroniser; all RX decoding uses the synchronised value.
REQ-019 start SHALL be accepted only in IDLE with 1 ≤ tx_len ≤ MAX_TX_BYTES and rx_len ≤ MAX_RX_BYTES; otherwise ignored, no done.
REQ-020 On accept: tx_data, tx_len, rx_len latched; rx_data, rx_count, timeout_err cleared; busy=1 next cycle.
REQ-021 States: IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_SAMPLE, RX_STOP, FINISH.
REQ-022 Each TX bit SHALL last 4 us: bit 0 = 3 us low + 1 us released; bit 1 = 1 us low + 3 us released; exactly 4*US_CYCLES clocks per bit.
REQ-023 After tx_len*8 bits, TX_STOP SHALL drive 1 us low then release 2 us (3*US_CYCLES clocks total).
REQ-024 jb_drive_low SHALL be 0 in every state except low phases of TX_LOW/TX_STOP.
REQ-025 rx_len=0: TX_STOP end -> FINISH directly.
REQ-026 RX_WAIT: on synchronised falling edge -> RX_SAMPLE; timer restarts on every entry.
REQ-027 RX_SAMPLE: sample line 2*US_CYCLES clocks after edge; high = 1, low = 0; shift into current byte MSB-first.
REQ-028 After each 8th bit, byte stored at index rx_count and rx_count increments.
REQ-029 After sampling, wait for line high before returning to RX_WAIT (edge re-armed only after high seen).
REQ-030 After rx_len*8 bits -> RX_STOP: wait for falling then rising edge of device stop bit, then FINISH.
REQ-031 Timeout: line high for TIMEOUT_US*US_CYCLES consecutive clocks in RX_WAIT or RX_STOP, or line low that long in any RX state -> FINISH with timeout_err=1; partial bytes discarded, complete bytes kept.
REQ-032 FINISH: done=1 for exactly one cycle, busy=0 same cycle, next state IDLE.
REQ-033 start asserted while busy SHALL be ignored without effect on the ongoing transaction.
REQ-034 All counters SHALL be sized for their maximum value with no wrap; bit counter saturates at rx_len*8.

Reset
REQ-035 rst SHALL force IDLE, jb_drive_low=0, busy=0, done=0, timeout_err=0, rx_data=0, rx_count=0, synchroniser=1 (line idle high).
REQ-036 rst mid-transaction SHALL abort within one cycle, release the line, no done pulse.

Verification (US_CYCLES=4, TIMEOUT_US=10)
REQ-037 start, tx_len=1, tx_data=0x01, rx_len=0 -> 7 bits of 12 clk low/4 released, 1 bit 4 low/12 released, stop 4 low/8 released; done 1 cycle later, timeout_err=0.
REQ-038 tx 0x01, rx_len=4, device model replies 0x80,0x00,0x12,0x34 + stop -> rx_data=0x34120080, rx_count=4, done, timeout_err=0.
REQ-039 tx 0x01, rx_len=4, no device reply -> done 40 clk after RX_WAIT entry, timeout_err=1, rx_count=0.
REQ-040 device sends 2 bytes 0xAA,0x55 then goes silent, rx_len=4 -> timeout_err=1, rx_count=2, rx_data[15:0]=0x55AA.
REQ-041 start while busy, and start with tx_len=0 in IDLE -> no state change, no extra done.
REQ-042 rst asserted during TX_LOW -> next cycle jb_drive_low=0, busy=0, no done; subsequent start works normally.
